// File: rtl/decode_sequencer.sv
// Instruction decode and sequencing control: walks IDLE -> LOAD -> EXEC, detours
// through MEM for loads/stores, and parks in HALT until the next init.
module decode_sequencer (
   input  logic       clk,
   input  logic       init,
   input  logic       start,
   input  logic [8:0] inst,
   input  logic       eq_flag,
   input  logic [7:0] rs_data,
   input  logic       mem_ack,
   output logic [1:0] rs_sel,
   output logic       pc_init,
   output logic       fetch_unit_en,
   output logic       branch,
   output logic       branchi,
   output logic [7:0] target,
   output logic [5:0] immediate,
   output logic       mem_req,
   output logic       mem_we,
   output logic       halted
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_EXEC = 3'd2,
      S_MEM  = 3'd3,
      S_HALT = 3'd4
   } state_t;

   state_t     state_q, state_d;
   logic       mem_we_q, mem_we_d;
   logic       armed_q, armed_d;
   logic [2:0] opcode;
   logic [1:0] sub;

   assign opcode = inst[8:6];
   assign sub    = inst[5:4];
   assign rs_sel = inst[1:0];

   // armed_q blocks a start that coincides with the first edge after reset release
   always_ff @(posedge clk or posedge init) begin
      if (init) begin
         state_q  <= S_IDLE;
         mem_we_q <= 1'b0;
         armed_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         mem_we_q <= mem_we_d;
         armed_q  <= armed_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      mem_we_d      = mem_we_q;
      armed_d       = armed_q;
      pc_init       = 1'b0;
      fetch_unit_en = 1'b0;
      branch        = 1'b0;
      branchi       = 1'b0;
      target        = 8'd0;
      immediate     = 6'd0;
      mem_req       = 1'b0;
      mem_we        = 1'b0;
      halted        = 1'b0;

      case (state_q)
         S_IDLE: begin
            armed_d = 1'b1;
            if (armed_q && start) state_d = S_LOAD;
         end
         S_LOAD: begin
            pc_init = 1'b1;
            state_d = S_EXEC;
         end
         S_EXEC: begin
            if (inst == 9'b000000001) begin
               state_d = S_HALT;
            end else if (inst[8:2] == 7'b0000010) begin
               fetch_unit_en = 1'b1;
               branch        = 1'b1;
               target        = rs_data;
            end else if (inst[8:2] == 7'b0000001) begin
               fetch_unit_en = 1'b1;
               branch        = eq_flag;
               target        = eq_flag ? rs_data : 8'd0;
            end else if (opcode == 3'b010 && sub == 2'b11) begin
               fetch_unit_en = 1'b1;
               branchi       = eq_flag;
               immediate     = eq_flag ? {2'b00, inst[3:0]} : 6'd0;
            end else if (opcode == 3'b111) begin
               fetch_unit_en = 1'b1;
               branchi       = 1'b1;
               immediate     = inst[5:0];
            end else if (opcode == 3'b010 && !sub[1]) begin
               state_d  = S_MEM;
               mem_we_d = sub[0];
            end else begin
               fetch_unit_en = 1'b1;
            end
         end
         S_MEM: begin
            mem_req = 1'b1;
            mem_we  = mem_we_q;
            if (mem_ack) begin
               fetch_unit_en = 1'b1;
               state_d       = S_EXEC;
            end
         end
         S_HALT: begin
            halted = 1'b1;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_decode_sequencer.sv
// Directed bench for decode_sequencer: reset, start handshake, each decode class,
// memory wait with ack, asynchronous reset inside MEM, and HALT lock-up.
module tb_decode_sequencer;

   logic       clk;
   logic       init;
   logic       start;
   logic [8:0] inst;
   logic       eq_flag;
   logic [7:0] rs_data;
   logic       mem_ack;
   logic [1:0] rs_sel;
   logic       pc_init;
   logic       fetch_unit_en;
   logic       branch;
   logic       branchi;
   logic [7:0] target;
   logic [5:0] immediate;
   logic       mem_req;
   logic       mem_we;
   logic       halted;

   int tests_run;
   int tests_failed;

   localparam logic [8:0] INST_ALU  = 9'b001010001;
   localparam logic [8:0] INST_JMPI = 9'b111000011;
   localparam logic [8:0] INST_JMP  = 9'b000001000;
   localparam logic [8:0] INST_BEQ  = 9'b000000100;
   localparam logic [8:0] INST_BEQI = 9'b010110101;
   localparam logic [8:0] INST_ST   = 9'b010010110;
   localparam logic [8:0] INST_LD   = 9'b010000010;
   localparam logic [8:0] INST_HALT = 9'b000000001;

   decode_sequencer dut (
      .clk           (clk),
      .init          (init),
      .start         (start),
      .inst          (inst),
      .eq_flag       (eq_flag),
      .rs_data       (rs_data),
      .mem_ack       (mem_ack),
      .rs_sel        (rs_sel),
      .pc_init       (pc_init),
      .fetch_unit_en (fetch_unit_en),
      .branch        (branch),
      .branchi       (branchi),
      .target        (target),
      .immediate     (immediate),
      .mem_req       (mem_req),
      .mem_we        (mem_we),
      .halted        (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
      end else begin
         $display("[TB] ok   %s = 0x%0h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      init    = 1'b1;
      start   = 1'b0;
      inst    = INST_ALU;
      eq_flag = 1'b0;
      rs_data = 8'h00;
      mem_ack = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      check("rst_pc_init", pc_init, 0);
      check("rst_feu", fetch_unit_en, 0);
      check("rst_branch", branch, 0);
      check("rst_branchi", branchi, 0);
      check("rst_mem_req", mem_req, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_halted", halted, 0);
      check("rst_target", target, 0);
      check("rst_immediate", immediate, 0);

      // start raised together with reset release must not launch the sequencer
      init  = 1'b0;
      start = 1'b1;
      tick();
      check("start_ignored_pc_init", pc_init, 0);
      tick();
      check("load_pc_init", pc_init, 1);
      check("load_feu", fetch_unit_en, 0);
      start = 1'b0;
      tick();
      check("exec_pc_init", pc_init, 0);
      check("alu_feu", fetch_unit_en, 1);
      check("alu_branch", branch, 0);
      check("alu_branchi", branchi, 0);
      check("alu_rs_sel", rs_sel, 2'd1);

      tick();
      inst = INST_JMPI;
      #1;
      check("jmpi_branchi", branchi, 1);
      check("jmpi_immediate", immediate, 6'd3);
      check("jmpi_feu", fetch_unit_en, 1);
      check("jmpi_branch", branch, 0);

      tick();
      inst    = INST_JMP;
      rs_data = 8'h2A;
      #1;
      check("jmp_branch", branch, 1);
      check("jmp_target", target, 8'h2A);
      check("jmp_feu", fetch_unit_en, 1);
      check("jmp_immediate", immediate, 0);

      tick();
      inst    = INST_BEQ;
      eq_flag = 1'b0;
      #1;
      check("beq_nt_branch", branch, 0);
      check("beq_nt_target", target, 0);
      check("beq_nt_feu", fetch_unit_en, 1);

      tick();
      eq_flag = 1'b1;
      #1;
      check("beq_t_branch", branch, 1);
      check("beq_t_target", target, 8'h2A);

      tick();
      inst    = INST_BEQI;
      eq_flag = 1'b1;
      #1;
      check("beqi_t_branchi", branchi, 1);
      check("beqi_t_immediate", immediate, 6'd5);
      check("beqi_t_branch", branch, 0);

      tick();
      eq_flag = 1'b0;
      #1;
      check("beqi_nt_branchi", branchi, 0);
      check("beqi_nt_immediate", immediate, 0);
      check("beqi_nt_feu", fetch_unit_en, 1);

      // store: EXEC issues no fetch, then MEM waits three cycles for ack
      tick();
      inst = INST_ST;
      #1;
      check("st_exec_feu", fetch_unit_en, 0);
      check("st_exec_mem_req", mem_req, 0);
      tick();
      check("st_mem_req", mem_req, 1);
      check("st_mem_we", mem_we, 1);
      check("st_mem_feu_c1", fetch_unit_en, 0);
      check("st_mem_target", target, 0);
      tick();
      check("st_mem_feu_c2", fetch_unit_en, 0);
      check("st_mem_req_c2", mem_req, 1);
      tick();
      mem_ack = 1'b1;
      #1;
      check("st_ack_feu", fetch_unit_en, 1);
      check("st_ack_mem_req", mem_req, 1);
      tick();
      mem_ack = 1'b0;
      inst    = INST_ALU;
      #1;
      check("st_back_mem_req", mem_req, 0);
      check("st_back_feu", fetch_unit_en, 1);

      // ack outside MEM is ignored
      tick();
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      #1;
      check("stray_ack_mem_req", mem_req, 0);
      check("stray_ack_feu", fetch_unit_en, 1);

      tick();
      inst = INST_LD;
      #1;
      check("ld_exec_feu", fetch_unit_en, 0);
      tick();
      check("ld_mem_req", mem_req, 1);
      check("ld_mem_we", mem_we, 0);
      check("ld_rs_sel", rs_sel, 2'd2);

      // asynchronous reset between edges while waiting in MEM
      #3;
      init = 1'b1;
      inst = INST_ALU;
      #1;
      check("async_rst_mem_req", mem_req, 0);
      check("async_rst_mem_we", mem_we, 0);
      check("async_rst_feu", fetch_unit_en, 0);
      tick();
      init  = 1'b0;
      start = 1'b1;
      tick();
      check("restart_ignored", pc_init, 0);
      tick();
      check("restart_load", pc_init, 1);
      start = 1'b0;
      tick();
      check("restart_exec_feu", fetch_unit_en, 1);
      check("restart_mem_req", mem_req, 0);

      tick();
      inst = INST_HALT;
      #1;
      check("halt_exec_feu", fetch_unit_en, 0);
      check("halt_exec_halted", halted, 0);
      tick();
      inst = INST_ALU;
      #1;
      check("halt_halted", halted, 1);
      for (int i = 0; i < 10; i++) begin
         start = (i % 2 == 0);
         tick();
         check($sformatf("halt_hold_feu_%0d", i), fetch_unit_en, 0);
         check($sformatf("halt_hold_halted_%0d", i), halted, 1);
      end
      start = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
